alu_cmd_sequencer: RTL and testbench

Byte-serial command front-end that acts as the initiator for the 8-bit ALU. It collects an opcode byte and operand bytes over a valid/ready stream, drives registered operands and a select onto the ALU's combinational inputs, captures result and carry, and returns them over a second valid/ready stream. An internal accumulator supports chained operations without resending operand A.

---
 rtl/alu_cmd_sequencer_if.sv | 32 +++
 rtl/alu_cmd_sequencer.sv | 123 ++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/alu_cmd_sequencer_if.sv
// alu_cmd_sequencer_if
//   Bundles the sequencer's three buses:
//     - the byte-serial command stream (cmd_data, cmd_valid, cmd_ready)
//     - the combinational ALU operand/result bus (alu_a, alu_b, alu_sel,
//       alu_result, alu_carry)
//     - the response stream (rsp_data, rsp_carry, rsp_valid, rsp_ready)
//   master : the sequencer's view of these buses
//   slave  : the view of the command source, the ALU and the response sink
interface alu_cmd_sequencer_if;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_sel;
    logic [7:0] alu_result;
    logic       alu_carry;
    logic [7:0] rsp_data;
    logic       rsp_carry;
    logic       rsp_valid;
    logic       rsp_ready;

    modport master (
        input  cmd_data, cmd_valid, alu_result, alu_carry, rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_sel, rsp_data, rsp_carry, rsp_valid
    );

    modport slave (
        output cmd_data, cmd_valid, alu_result, alu_carry, rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_sel, rsp_data, rsp_carry, rsp_valid
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//   Byte-serial initiator for an 8-bit combinational ALU. It collects an opcode
//   byte plus up to two operand bytes, holds registered operands and the select
//   on the ALU inputs, samples the result and carry for one cycle, and returns
//   them on the response stream. The accumulator keeps the last result, so a
//   CHAIN opcode can use it as operand A without resending it.
//   Opcode byte: [2:0] sel, [3] CHAIN (A := acc), [4] UNARY (B := 0), [7:5] unused.
// Ports
//   clk, rst_n : clock; asynchronous active-low reset
//   bus        : command stream, ALU bus and response stream (master side)
//   acc        : accumulator, the last result
//   op_count   : number of executed operations, wraps at 8 bits
module alu_cmd_sequencer #(
    parameter logic [7:0] ACC_RESET = 8'h00
) (
    input  logic                       clk,
    input  logic                       rst_n,
    alu_cmd_sequencer_if.master        bus,
    output logic [7:0]                 acc,
    output logic [7:0]                 op_count
);

    typedef enum logic [2:0] {IDLE, GET_A, GET_B, EXEC, RESP} state_t;

    state_t     state, next_state;
    logic       cmd_ready_q;
    logic [7:0] alu_a_q, alu_b_q;
    logic [2:0] alu_sel_q;
    logic [7:0] rsp_data_q;
    logic       rsp_carry_q, rsp_valid_q;
    logic       unary_q;            // UNARY flag carried from IDLE into GET_A

    logic       cmd_fire;
    logic       op_chain, op_unary;
    logic       ld_op, ld_a_acc, ld_a_byte, ld_b_byte, ld_b_zero, do_exec, rsp_take;

    logic       unused_opcode_bits;
    assign unused_opcode_bits = &{1'b0, bus.cmd_data[7:5]};

    assign cmd_fire = bus.cmd_valid & cmd_ready_q;
    assign op_chain = bus.cmd_data[3];
    assign op_unary = bus.cmd_data[4];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (cmd_fire) begin
                       if (!op_chain)      next_state = GET_A;
                       else if (!op_unary) next_state = GET_B;
                       else                next_state = EXEC;
                   end
            GET_A: if (cmd_fire) next_state = unary_q ? EXEC : GET_B;
            GET_B: if (cmd_fire) next_state = EXEC;
            EXEC:  next_state = RESP;
            RESP:  if (bus.rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output / load-enable decode
    always_comb begin
        ld_op     = (state == IDLE)  && cmd_fire;
        ld_a_acc  = ld_op && op_chain;
        ld_a_byte = (state == GET_A) && cmd_fire;
        ld_b_byte = (state == GET_B) && cmd_fire;
        ld_b_zero = (ld_a_acc && op_unary) || (ld_a_byte && unary_q);
        do_exec   = (state == EXEC);
        rsp_take  = (state == RESP) && bus.rsp_ready;
    end

    // Datapath registers. cmd_ready is looked up from next_state so that it
    // is a flop yet already correct in the cycle the state is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready_q <= 1'b0;
            alu_a_q     <= 8'h00;
            alu_b_q     <= 8'h00;
            alu_sel_q   <= 3'b000;
            unary_q     <= 1'b0;
            rsp_data_q  <= 8'h00;
            rsp_carry_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            acc         <= ACC_RESET;
            op_count    <= 8'h00;
        end else begin
            cmd_ready_q <= (next_state == IDLE) || (next_state == GET_A) ||
                           (next_state == GET_B);
            if (ld_op) begin
                alu_sel_q <= bus.cmd_data[2:0];
                unary_q   <= op_unary;
            end
            if (ld_a_acc)       alu_a_q <= acc;
            else if (ld_a_byte) alu_a_q <= bus.cmd_data;
            if (ld_b_zero)      alu_b_q <= 8'h00;
            else if (ld_b_byte) alu_b_q <= bus.cmd_data;
            if (do_exec) begin
                rsp_data_q  <= bus.alu_result;
                rsp_carry_q <= bus.alu_carry;
                rsp_valid_q <= 1'b1;
                acc         <= bus.alu_result;
                op_count    <= op_count + 8'h01;
            end else if (rsp_take) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_sel   = alu_sel_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_carry = rsp_carry_q;
    assign bus.rsp_valid = rsp_valid_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer
//   Directed bench for alu_cmd_sequencer with a behavioural 8-bit ALU:
//   0 add, 1 sub, 2 and, 3 or, 4 xor, 5 shl, 6 shr, 7 pass A.
//   Carry is produced only by add/sub; every other select returns carry 0.
module tb_alu_cmd_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_cmd_sequencer_if bus();
    logic [7:0] acc, op_count;

    alu_cmd_sequencer #(.ACC_RESET(8'hA5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.master),
        .acc      (acc),
        .op_count (op_count)
    );

    // Combinational ALU
    always_comb begin
        logic [8:0] t;
        t = 9'h000;
        case (bus.alu_sel)
            3'd0: t = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            3'd1: t = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
            3'd2: t = {1'b0, bus.alu_a & bus.alu_b};
            3'd3: t = {1'b0, bus.alu_a | bus.alu_b};
            3'd4: t = {1'b0, bus.alu_a ^ bus.alu_b};
            3'd5: t = {1'b0, bus.alu_a[6:0], 1'b0};
            3'd6: t = {2'b00, bus.alu_a[7:1]};
            default: t = {1'b0, bus.alu_a};
        endcase
        bus.alu_result = t[7:0];
        bus.alu_carry  = t[8];
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present a byte and return #1 after the edge that accepted it.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.cmd_data  = b;
        bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!bus.cmd_ready) chk("send_timeout", 32'(n), 32'd0);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    // Called right after the last command byte was accepted: the response
    // must appear after exactly one more edge, then is accepted immediately.
    task automatic get_rsp(input string tag, input logic [7:0] d, input logic c);
        int n = 0;
        while (!bus.rsp_valid && n < 10) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_lat"},   32'(n), 32'd1);
        chk({tag, "_data"},  {24'h0, bus.rsp_data}, {24'h0, d});
        chk({tag, "_carry"}, {31'h0, bus.rsp_carry}, {31'h0, c});
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk({tag, "_idle_rdy"}, {31'h0, bus.cmd_ready}, 32'd1);
        chk({tag, "_vld_clr"},  {31'h0, bus.rsp_valid}, 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, {31'h0, bus.cmd_ready}, 32'd0);
        chk({tag, "_alu_a"},     {24'h0, bus.alu_a},     32'h00);
        chk({tag, "_alu_b"},     {24'h0, bus.alu_b},     32'h00);
        chk({tag, "_alu_sel"},   {29'h0, bus.alu_sel},   32'h0);
        chk({tag, "_rsp_data"},  {24'h0, bus.rsp_data},  32'h00);
        chk({tag, "_rsp_carry"}, {31'h0, bus.rsp_carry}, 32'd0);
        chk({tag, "_rsp_valid"}, {31'h0, bus.rsp_valid}, 32'd0);
        chk({tag, "_acc"},       {24'h0, acc},           32'hA5);
        chk({tag, "_op_count"},  {24'h0, op_count},      32'h00);
    endtask

    initial begin
        bus.cmd_data  = 8'h00;
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        chk("rst_rel_rdy0", {31'h0, bus.cmd_ready}, 32'd0);
        @(posedge clk); #1;
        chk("rst_rel_rdy1", {31'h0, bus.cmd_ready}, 32'd1);

        // Add with carry out
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h01);
        chk("add_exec_rdy", {31'h0, bus.cmd_ready}, 32'd0);
        get_rsp("add", 8'h00, 1'b1);
        chk("add_acc", {24'h0, acc}, 32'h00);
        chk("add_cnt", {24'h0, op_count}, 32'h01);

        // Chain: 0x10 + 0x05, then acc | 0x80 with no A byte
        send_byte(8'h00); send_byte(8'h10); send_byte(8'h05);
        get_rsp("chn1", 8'h15, 1'b0);
        send_byte(8'h0B);
        chk("chn_alu_a", {24'h0, bus.alu_a}, 32'h15);
        chk("chn_getb_rdy", {31'h0, bus.cmd_ready}, 32'd1);
        send_byte(8'h80);
        chk("chn_alu_b", {24'h0, bus.alu_b}, 32'h80);
        get_rsp("chn2", 8'h95, 1'b0);
        chk("chn_acc", {24'h0, acc}, 32'h95);

        // Unary shift left, then opcode-only shift right of acc
        send_byte(8'h15); send_byte(8'hC3);
        chk("un_alu_b", {24'h0, bus.alu_b}, 32'h00);
        chk("un_alu_sel", {29'h0, bus.alu_sel}, 32'h5);
        get_rsp("un_shl", 8'h86, 1'b0);
        send_byte(8'h1E);
        chk("un2_alu_a", {24'h0, bus.alu_a}, 32'h86);
        get_rsp("un_shr", 8'h43, 1'b0);
        chk("un_cnt", {24'h0, op_count}, 32'h05);

        // Backpressure: 1 + 2, response held while a pass-A opcode waits
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h02);
        @(posedge clk); #1;
        bus.cmd_data  = 8'h1F;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("bp_vld",  {31'h0, bus.rsp_valid}, 32'd1);
            chk("bp_data", {24'h0, bus.rsp_data},  32'h03);
            chk("bp_rdy",  {31'h0, bus.cmd_ready}, 32'd0);
            @(posedge clk); #1;
        end
        chk("bp_cnt", {24'h0, op_count}, 32'h06);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk("bp_rel_rdy", {31'h0, bus.cmd_ready}, 32'd1);
        chk("bp_rel_vld", {31'h0, bus.rsp_valid}, 32'd0);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        chk("bp_op_taken", {31'h0, bus.cmd_ready}, 32'd0);
        get_rsp("bp_pass", 8'h03, 1'b0);
        chk("bp_cnt2", {24'h0, op_count}, 32'h07);

        // Reset mid-command, after the A byte
        send_byte(8'h00); send_byte(8'h02);
        chk("mid_alu_a", {24'h0, bus.alu_a}, 32'h02);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_byte(8'h00); send_byte(8'h02); send_byte(8'h03);
        get_rsp("mid_new", 8'h05, 1'b0);
        chk("mid_cnt", {24'h0, op_count}, 32'h01);
        chk("mid_acc", {24'h0, acc}, 32'h05);

        // op_count wrap over 256 operations from reset
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 256; i++) begin
            logic [8:0] s;
            s = 9'(i) + 9'h003;
            send_byte(8'h00); send_byte(8'(i)); send_byte(8'h03);
            get_rsp("wrap", s[7:0], s[8]);
            if (i == 254) chk("wrap_cnt_ff", {24'h0, op_count}, 32'hFF);
        end
        chk("wrap_cnt", {24'h0, op_count}, 32'h00);
        chk("wrap_acc", {24'h0, acc}, 32'h02);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
